// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline writeback stage.
// - wb_sel_e   : writeback result select (codes 5-7 fall back to ALU)
// - SZ_B/H/W   : load byte-lane masks carried with each load
// - wb_state_e : writeback FSM states
package core_pkg;

    typedef enum logic [2:0] {
        WB_ALU = 3'd0,
        WB_MEM = 3'd1,
        WB_PC4 = 3'd2,
        WB_IMM = 3'd3,
        WB_CSR = 3'd4
    } wb_sel_e;

    localparam logic [3:0] SZ_B = 4'b0001;
    localparam logic [3:0] SZ_H = 4'b0011;
    localparam logic [3:0] SZ_W = 4'b1111;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_data_aligner.sv
// Combinational load-data aligner: picks the addressed byte/half out of the
// returned memory word and zero- or sign-extends it to XLEN.
// Ports:
//   rdata       in  XLEN  raw data-memory read word
//   size        in  4     byte mask (SZ_B, SZ_H, anything else = word)
//   is_unsigned in  1     1 = zero-extend, 0 = sign-extend
//   addr_lo     in  2     load address bits [1:0]
//   data        out XLEN  aligned, extended load value
import core_pkg::*;

module load_data_aligner #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [3:0]      size,
    input  logic            is_unsigned,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        // addr_lo[0] is ignored for halves; misaligned halves never reach here.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        if (size == SZ_B) begin
            data = {{(XLEN-8){byte_sel[7] & ~is_unsigned}}, byte_sel};
        end else if (size == SZ_H) begin
            data = {{(XLEN-16){half_sel[15] & ~is_unsigned}}, half_sel};
        end
    end

endmodule

// File: rtl/core_wb_stage.sv
// Writeback stage: selects the instruction result, aligns/extends load data
// and drives the register-file write port. A load whose memory response is
// not back yet is captured and the pipeline is stalled until it returns.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | accepting MEM-stage instructions each cycle
// LOAD_WAIT | load captured, waiting for i_dmem_rvalid; MEM inputs ignored
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_valid .. i_csr_rdata    MEM-stage instruction and its candidate results
//   i_dmem_rvalid/rdata       data-memory read response
//   o_stall                   combinational hold for upstream stages
//   o_wb_rd/o_rd_din          registered write address / data
//   o_wb_reg_write            registered one-cycle write enable
//   o_spurious_rsp            one-cycle pulse: response with no load pending
import core_pkg::*;

module core_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [4:0]      i_rd,
    input  logic            i_reg_write,
    input  logic            i_mem_read,
    input  logic [2:0]      i_mem_to_reg,
    input  logic [3:0]      i_d_size,
    input  logic            i_d_unsigned,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_pc_plus4,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_csr_rdata,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_stall,
    output logic [4:0]      o_wb_rd,
    output logic            o_wb_reg_write,
    output logic [XLEN-1:0] o_rd_din,
    output logic            o_spurious_rsp
);

    wb_state_e       state_q;
    logic [4:0]      cap_rd;
    logic            cap_reg_write;
    logic [3:0]      cap_size;
    logic            cap_unsigned;
    logic [1:0]      cap_addr_lo;

    logic [3:0]      al_size;
    logic            al_unsigned;
    logic [1:0]      al_addr_lo;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] sel_result;

    // While waiting, the aligner must use the captured load attributes since
    // the MEM-stage inputs may already belong to a different instruction.
    always_comb begin
        al_size     = i_d_size;
        al_unsigned = i_d_unsigned;
        al_addr_lo  = i_addr_lo;
        if (state_q == LOAD_WAIT) begin
            al_size     = cap_size;
            al_unsigned = cap_unsigned;
            al_addr_lo  = cap_addr_lo;
        end
    end

    load_data_aligner #(.XLEN(XLEN)) u_aligner (
        .rdata       (i_dmem_rdata),
        .size        (al_size),
        .is_unsigned (al_unsigned),
        .addr_lo     (al_addr_lo),
        .data        (load_data)
    );

    always_comb begin
        sel_result = i_alu_result;
        case (i_mem_to_reg)
            WB_MEM:  sel_result = load_data;
            WB_PC4:  sel_result = i_pc_plus4;
            WB_IMM:  sel_result = i_imm;
            WB_CSR:  sel_result = i_csr_rdata;
            default: sel_result = i_alu_result;
        endcase
    end

    always_comb begin
        o_stall = 1'b0;
        if (state_q == IDLE) begin
            o_stall = i_valid && i_mem_read && !i_dmem_rvalid;
        end else begin
            o_stall = !i_dmem_rvalid;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            cap_rd         <= '0;
            cap_reg_write  <= 1'b0;
            cap_size       <= '0;
            cap_unsigned   <= 1'b0;
            cap_addr_lo    <= '0;
            o_wb_rd        <= '0;
            o_wb_reg_write <= 1'b0;
            o_rd_din       <= '0;
            o_spurious_rsp <= 1'b0;
        end else begin
            o_wb_reg_write <= 1'b0;
            o_spurious_rsp <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_valid && !i_mem_read) begin
                        o_wb_rd        <= i_rd;
                        o_rd_din       <= sel_result;
                        o_wb_reg_write <= i_reg_write && (i_rd != 5'd0);
                        o_spurious_rsp <= i_dmem_rvalid;
                    end else if (i_valid && i_mem_read) begin
                        if (i_dmem_rvalid) begin
                            o_wb_rd        <= i_rd;
                            o_rd_din       <= load_data;
                            o_wb_reg_write <= i_reg_write && (i_rd != 5'd0);
                        end else begin
                            cap_rd        <= i_rd;
                            cap_reg_write <= i_reg_write;
                            cap_size      <= i_d_size;
                            cap_unsigned  <= i_d_unsigned;
                            cap_addr_lo   <= i_addr_lo;
                            state_q       <= LOAD_WAIT;
                        end
                    end else begin
                        o_spurious_rsp <= i_dmem_rvalid;
                    end
                end
                LOAD_WAIT: begin
                    if (i_dmem_rvalid) begin
                        o_wb_rd        <= cap_rd;
                        o_rd_din       <= load_data;
                        o_wb_reg_write <= cap_reg_write && (cap_rd != 5'd0);
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_wb_stage.sv
// Bench for core_wb_stage: directed table, hand-written multi-cycle
// sequences, and random traffic against a behavioural model.
module tb_core_wb_stage;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic [2:0]  sel;
        logic [3:0]  size;
        logic        uns;
        logic [1:0]  addr;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [31:0] csr;
        logic        rv;
        logic [31:0] rdata;
    } in_t;

    typedef struct {
        in_t         i;
        logic        e_stall;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_din;
        logic        e_sp;
        logic        chk_data;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        valid, reg_write, mem_read, d_unsigned, dmem_rvalid;
    logic [4:0]  rd;
    logic [2:0]  mem_to_reg;
    logic [3:0]  d_size;
    logic [1:0]  addr_lo;
    logic [31:0] alu_result, pc_plus4, imm, csr_rdata, dmem_rdata;
    logic        stall, wb_reg_write, spurious;
    logic [4:0]  wb_rd;
    logic [31:0] rd_din;

    int checks = 0;
    int failures = 0;

    core_wb_stage #(.XLEN(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (valid),
        .i_rd           (rd),
        .i_reg_write    (reg_write),
        .i_mem_read     (mem_read),
        .i_mem_to_reg   (mem_to_reg),
        .i_d_size       (d_size),
        .i_d_unsigned   (d_unsigned),
        .i_addr_lo      (addr_lo),
        .i_alu_result   (alu_result),
        .i_pc_plus4     (pc_plus4),
        .i_imm          (imm),
        .i_csr_rdata    (csr_rdata),
        .i_dmem_rvalid  (dmem_rvalid),
        .i_dmem_rdata   (dmem_rdata),
        .o_stall        (stall),
        .o_wb_rd        (wb_rd),
        .o_wb_reg_write (wb_reg_write),
        .o_rd_din       (rd_din),
        .o_spurious_rsp (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        valid = v.valid; rd = v.rd; reg_write = v.rw; mem_read = v.mr;
        mem_to_reg = v.sel; d_size = v.size; d_unsigned = v.uns; addr_lo = v.addr;
        alu_result = v.alu; pc_plus4 = v.pc4; imm = v.imm; csr_rdata = v.csr;
        dmem_rvalid = v.rv; dmem_rdata = v.rdata;
    endtask

    function automatic in_t idle_in();
        in_t v;
        v = '{valid: 0, rd: 0, rw: 0, mr: 0, sel: 0, size: 4'hF, uns: 0, addr: 0,
              alu: 0, pc4: 0, imm: 0, csr: 0, rv: 0, rdata: 0};
        return v;
    endfunction

    // Reference load extraction by shifting and masking.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [3:0] sz,
                                             input logic u, input logic [1:0] a);
        logic [31:0] v;
        if (sz == 4'b0001) begin
            v = (w >> (8 * int'(a))) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 4'b0011) begin
            v = (w >> (16 * (int'(a) / 2))) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Apply one cycle: drive at negedge, check stall, then registered outputs after posedge.
    task automatic run_cycle(input string name, input int idx, input in_t v,
                             input logic e_stall, input logic e_we, input logic [4:0] e_rd,
                             input logic [31:0] e_din, input logic e_sp, input logic chk_data);
        drive(v);
        #1;
        check({name, ".stall"}, idx, {31'd0, stall}, {31'd0, e_stall});
        @(posedge clk);
        #1;
        check({name, ".we"}, idx, {31'd0, wb_reg_write}, {31'd0, e_we});
        check({name, ".sp"}, idx, {31'd0, spurious}, {31'd0, e_sp});
        if (chk_data) begin
            check({name, ".rd"}, idx, {27'd0, wb_rd}, {27'd0, e_rd});
            check({name, ".din"}, idx, rd_din, e_din);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(idle_in());
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Model state for random phase.
    logic        m_pend;
    logic [4:0]  m_prd;
    logic        m_prw;
    logic [3:0]  m_psz;
    logic        m_pu;
    logic [1:0]  m_pa;
    logic [4:0]  m_rd;
    logic [31:0] m_din;

    vec_t tbl[$];
    in_t  v;
    in_t  b;

    initial begin
        rst_n = 1'b1;
        drive(idle_in());
        @(negedge clk);
        do_reset();
        check("reset.rd", 0, {27'd0, wb_rd}, 32'd0);
        check("reset.din", 0, rd_din, 32'd0);
        check("reset.we", 0, {31'd0, wb_reg_write}, 32'd0);
        check("reset.sp", 0, {31'd0, spurious}, 32'd0);
        check("reset.stall", 0, {31'd0, stall}, 32'd0);

        // Directed single-cycle table.
        b = idle_in();
        v = b; v.valid = 1; v.rd = 5;  v.rw = 1; v.sel = 0; v.alu = 32'h0000_1234;
        tbl.push_back('{v, 0, 1, 5, 32'h0000_1234, 0, 1});
        v = b; v.valid = 1; v.rd = 0;  v.rw = 1; v.sel = 0; v.alu = 32'h0000_AAAA;
        tbl.push_back('{v, 0, 0, 0, 32'h0000_AAAA, 0, 1});
        v = b; v.valid = 1; v.rd = 7;  v.rw = 1; v.mr = 1; v.sel = 1; v.size = 4'b0001; v.addr = 3;
        v.rv = 1; v.rdata = 32'h8000_0000;
        tbl.push_back('{v, 0, 1, 7, 32'hFFFF_FF80, 0, 1});
        v = b; v.valid = 1; v.rd = 1;  v.rw = 1; v.sel = 2; v.pc4 = 32'h0000_0104; v.alu = 32'h11;
        tbl.push_back('{v, 0, 1, 1, 32'h0000_0104, 0, 1});
        v = b; v.valid = 1; v.rd = 2;  v.rw = 1; v.sel = 3; v.imm = 32'hABCD_E000; v.alu = 32'h22;
        tbl.push_back('{v, 0, 1, 2, 32'hABCD_E000, 0, 1});
        v = b; v.valid = 1; v.rd = 3;  v.rw = 1; v.sel = 4; v.csr = 32'h0000_0300; v.alu = 32'h33;
        tbl.push_back('{v, 0, 1, 3, 32'h0000_0300, 0, 1});
        v = b; v.valid = 1; v.rd = 4;  v.rw = 1; v.sel = 6; v.alu = 32'h0000_0055; v.imm = 32'h66;
        tbl.push_back('{v, 0, 1, 4, 32'h0000_0055, 0, 1});
        v = b; v.valid = 1; v.rd = 8;  v.rw = 1; v.mr = 1; v.sel = 1; v.size = 4'b0011; v.addr = 2;
        v.rv = 1; v.rdata = 32'h8001_1234;
        tbl.push_back('{v, 0, 1, 8, 32'hFFFF_8001, 0, 1});
        v = b; v.valid = 1; v.rd = 9;  v.rw = 1; v.mr = 1; v.sel = 1; v.size = 4'b0011; v.addr = 1;
        v.uns = 1; v.rv = 1; v.rdata = 32'hFFFF_F00D;
        tbl.push_back('{v, 0, 1, 9, 32'h0000_F00D, 0, 1});
        v = b; v.valid = 1; v.rd = 10; v.rw = 1; v.mr = 1; v.sel = 1; v.size = 4'b0001; v.addr = 1;
        v.uns = 1; v.rv = 1; v.rdata = 32'h1234_8A56;
        tbl.push_back('{v, 0, 1, 10, 32'h0000_008A, 0, 1});
        v = b; v.valid = 1; v.rd = 11; v.rw = 1; v.mr = 1; v.sel = 1; v.size = 4'b1111;
        v.rv = 1; v.rdata = 32'hDEAD_BEEF;
        tbl.push_back('{v, 0, 1, 11, 32'hDEAD_BEEF, 0, 1});
        v = b; v.valid = 1; v.rd = 12; v.rw = 1; v.mr = 1; v.sel = 1; v.size = 4'b0001; v.addr = 0;
        v.rv = 1; v.rdata = 32'hFFFF_FF7F;
        tbl.push_back('{v, 0, 1, 12, 32'h0000_007F, 0, 1});
        v = b; v.valid = 1; v.rd = 13; v.rw = 0; v.sel = 0; v.alu = 32'h0BAD_F00D;
        tbl.push_back('{v, 0, 0, 13, 32'h0BAD_F00D, 0, 1});
        v = b; v.rv = 1; v.rdata = 32'h1111_1111;
        tbl.push_back('{v, 0, 0, 13, 32'h0BAD_F00D, 1, 1});
        v = b;
        tbl.push_back('{v, 0, 0, 13, 32'h0BAD_F00D, 0, 1});

        foreach (tbl[k]) begin
            run_cycle("tbl", k, tbl[k].i, tbl[k].e_stall, tbl[k].e_we, tbl[k].e_rd,
                      tbl[k].e_din, tbl[k].e_sp, tbl[k].chk_data);
        end

        // LHU with a response three cycles late; new MEM inputs must be ignored.
        v = b; v.valid = 1; v.rd = 6; v.rw = 1; v.mr = 1; v.sel = 1; v.size = 4'b0011;
        v.uns = 1; v.addr = 2;
        run_cycle("late.req", 0, v, 1, 0, 13, 32'h0BAD_F00D, 0, 1);
        v = b; v.valid = 1; v.rd = 14; v.rw = 1; v.sel = 0; v.alu = 32'hCAFE_0000;
        run_cycle("late.wait", 1, v, 1, 0, 13, 32'h0BAD_F00D, 0, 1);
        run_cycle("late.wait", 2, v, 1, 0, 13, 32'h0BAD_F00D, 0, 1);
        v.rv = 1; v.rdata = 32'hBEEF_0000;
        run_cycle("late.rsp", 3, v, 0, 1, 6, 32'h0000_BEEF, 0, 1);
        run_cycle("late.after", 4, b, 0, 0, 6, 32'h0000_BEEF, 0, 1);

        // Reset while waiting: a later response is spurious and writes nothing.
        v = b; v.valid = 1; v.rd = 6; v.rw = 1; v.mr = 1; v.sel = 1; v.size = 4'b1111;
        run_cycle("rstw.req", 0, v, 1, 0, 6, 32'h0000_BEEF, 0, 1);
        do_reset();
        check("rstw.din", 1, rd_din, 32'd0);
        v = b; v.rv = 1; v.rdata = 32'h5555_AAAA;
        run_cycle("rstw.rsp", 2, v, 0, 0, 0, 32'd0, 1, 1);

        // Random traffic against the behavioural model.
        do_reset();
        m_pend = 0; m_prd = 0; m_prw = 0; m_psz = 0; m_pu = 0; m_pa = 0;
        m_rd = 0; m_din = 0;
        for (int n = 0; n < 400; n++) begin
            logic        e_stall, e_we, e_sp;
            logic [31:0] res;
            int          sz_pick;
            v.valid = ($urandom_range(0, 9) < 7);
            v.rd    = 5'($urandom_range(0, 31));
            v.rw    = ($urandom_range(0, 9) < 8);
            v.mr    = ($urandom_range(0, 9) < 4);
            v.sel   = 3'($urandom_range(0, 7));
            if (!v.mr && v.sel == 3'd1) v.sel = 3'd0;
            sz_pick = $urandom_range(0, 3);
            v.size  = (sz_pick == 0) ? 4'b0001 : (sz_pick == 1) ? 4'b0011 :
                      (sz_pick == 2) ? 4'b1111 : 4'($urandom_range(0, 15));
            v.uns   = 1'($urandom_range(0, 1));
            v.addr  = 2'($urandom_range(0, 3));
            v.alu   = $urandom; v.pc4 = $urandom; v.imm = $urandom; v.csr = $urandom;
            v.rv    = ($urandom_range(0, 9) < 4);
            v.rdata = $urandom;

            e_we = 0; e_sp = 0;
            if (m_pend) begin
                e_stall = !v.rv;
                if (v.rv) begin
                    m_rd = m_prd; m_din = ref_load(v.rdata, m_psz, m_pu, m_pa);
                    e_we = m_prw && (m_prd != 0);
                    m_pend = 0;
                end
            end else if (v.valid && v.mr) begin
                e_stall = !v.rv;
                if (v.rv) begin
                    m_rd = v.rd; m_din = ref_load(v.rdata, v.size, v.uns, v.addr);
                    e_we = v.rw && (v.rd != 0);
                end else begin
                    m_pend = 1; m_prd = v.rd; m_prw = v.rw;
                    m_psz = v.size; m_pu = v.uns; m_pa = v.addr;
                end
            end else begin
                e_stall = 0;
                e_sp = v.rv;
                if (v.valid) begin
                    res = (v.sel == 2) ? v.pc4 : (v.sel == 3) ? v.imm :
                          (v.sel == 4) ? v.csr : v.alu;
                    m_rd = v.rd; m_din = res;
                    e_we = v.rw && (v.rd != 0);
                end
            end
            run_cycle("rand", n, v, e_stall, e_we, m_rd, m_din, e_sp, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
